// File: rtl/rfid_tag_packet_responder_pkg.sv
// Gen2 tag-side constants shared with the reader packet rxtx: opcode prefixes, frame lengths,
// tag inventory states and the slot-mask helper.
package rfid_tag_packet_responder_pkg;

    typedef enum logic [2:0] {
        StReady        = 3'd0,
        StArbitrate    = 3'd1,
        StReply        = 3'd2,
        StAcknowledged = 3'd3,
        StOpen         = 3'd4
    } tag_state_e;

    typedef enum logic [2:0] {
        CmdInvalid,
        CmdQueryRep,
        CmdAck,
        CmdQuery,
        CmdQueryAdj,
        CmdReqRn
    } cmd_e;

    // Frame lengths in bits, CRC included
    localparam logic [6:0] QueryRepLen = 7'd4;
    localparam logic [6:0] AckLen      = 7'd18;
    localparam logic [6:0] QueryLen    = 7'd22;
    localparam logic [6:0] QueryAdjLen = 7'd9;
    localparam logic [6:0] ReqRnLen    = 7'd40;

    localparam logic [1:0] QueryRepOp = 2'b00;
    localparam logic [1:0] AckOp      = 2'b01;
    localparam logic [3:0] QueryOp    = 4'b1000;
    localparam logic [3:0] QueryAdjOp = 4'b1001;
    localparam logic [7:0] ReqRnOp    = 8'b1100_0001;

    localparam logic [2:0] UpdnInc  = 3'b110;
    localparam logic [2:0] UpdnDec  = 3'b011;
    localparam logic [2:0] UpdnHold = 3'b000;

    localparam logic [15:0] LfsrTaps = 16'hB400;
    localparam logic [14:0] SlotWrap = 15'h7FFF;

    localparam logic [6:0] RepLenRn16   = 7'd16;
    localparam logic [6:0] RepLenEpc    = 7'd112;
    localparam logic [6:0] RepLenHandle = 7'd32;

    // (1 << q) - 1, limited to the 15-bit slot counter
    function automatic logic [14:0] slot_mask(input logic [3:0] q);
        logic [15:0] one_hot;
        one_hot = 16'd1 << q;
        return 15'(one_hot - 16'd1);
    endfunction

endpackage

// File: rtl/rfid_tag_rn16_lfsr.sv
// Free-running 16-bit Galois LFSR supplying RN16 values and slot draws; steps every clock.
module rfid_tag_rn16_lfsr
    import rfid_tag_packet_responder_pkg::*;
#(
    parameter logic [15:0] Seed = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] lfsr_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]};
        if (lfsr_q[0]) begin
            lfsr_d = lfsr_d ^ LfsrTaps;
        end
        // The all-zero state is a lock-up point; only reachable from a zero seed
        if (lfsr_d == 16'h0) begin
            lfsr_d = Seed;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= Seed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/rfid_tag_packet_responder.sv
// Tag-side Gen2 packet responder: collects decoded PIE bits, parses inventory commands, runs the
// tag inventory state machine and launches backscatter replies via a go pulse.
module rfid_tag_packet_responder
    import rfid_tag_packet_responder_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter logic [15:0] PC_WORD   = 16'h3000,
    parameter logic [95:0] EPC       = 96'h0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rx_start_i,
    input  logic         rx_bit_valid_i,
    input  logic         rx_bit_i,
    input  logic         rx_end_i,
    input  logic         tx_busy_i,
    output logic         tx_go_o,
    output logic [6:0]   tx_len_o,
    output logic [111:0] tx_data_o,
    output logic [2:0]   bs_miller_o,
    output logic         bs_trext_o,
    output logic         bs_dr_o,
    output logic [2:0]   tag_state_o,
    output logic [15:0]  handle_o
);

    logic [15:0] lfsr;

    rfid_tag_rn16_lfsr #(
        .Seed(LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .lfsr_o(lfsr)
    );

    // Bit collector
    logic [63:0] sr_q;
    logic [6:0]  cnt_q;
    logic        active_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q     <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (rx_start_i) begin
            sr_q     <= '0;
            cnt_q    <= '0;
            active_q <= 1'b1;
        end else begin
            if (rx_bit_valid_i && active_q) begin
                sr_q <= {sr_q[62:0], rx_bit_i};
                if (cnt_q != 7'd127) begin
                    cnt_q <= cnt_q + 7'd1;
                end
            end
            if (rx_end_i) begin
                active_q <= 1'b0;
            end
        end
    end

    // No accepted command is longer than 40 bits
    logic unused_sr;
    assign unused_sr = ^sr_q[63:40];

    // Inventory state
    tag_state_e    state_q;
    logic [3:0]    q_q;
    logic [14:0]   slot_q;
    logic [1:0]    session_q;
    logic [15:0]   handle_q;
    logic [2:0]    miller_q;
    logic          trext_q;
    logic          dr_q;
    logic          tx_go_q;
    logic [6:0]    tx_len_q;
    logic [111:0]  tx_data_q;

    // Command decode, valid only in the rx_end cycle
    cmd_e        cmd;
    logic [3:0]  adj_q;
    logic [3:0]  draw_q;
    logic [14:0] draw_slot;
    logic        frame_done;
    logic        in_round;
    logic        ack_match;
    logic        reqrn_ok;

    always_comb begin
        cmd   = CmdInvalid;
        adj_q = q_q;
        if (cnt_q == QueryRepLen && sr_q[3:2] == QueryRepOp && sr_q[1:0] == session_q) begin
            cmd = CmdQueryRep;
        end else if (cnt_q == AckLen && sr_q[17:16] == AckOp) begin
            cmd = CmdAck;
        end else if (cnt_q == QueryLen && sr_q[21:18] == QueryOp) begin
            cmd = CmdQuery;
        end else if (cnt_q == QueryAdjLen && sr_q[8:5] == QueryAdjOp
                     && sr_q[4:3] == session_q) begin
            case (sr_q[2:0])
                UpdnInc: begin
                    cmd   = CmdQueryAdj;
                    adj_q = (q_q == 4'hF) ? q_q : q_q + 4'd1;
                end
                UpdnDec: begin
                    cmd   = CmdQueryAdj;
                    adj_q = (q_q == 4'h0) ? q_q : q_q - 4'd1;
                end
                UpdnHold: cmd = CmdQueryAdj;
                default:  cmd = CmdInvalid;
            endcase
        end else if (cnt_q == ReqRnLen && sr_q[39:32] == ReqRnOp) begin
            cmd = CmdReqRn;
        end

        draw_q    = (cmd == CmdQuery) ? sr_q[8:5] : adj_q;
        draw_slot = lfsr[14:0] & slot_mask(draw_q);
    end

    assign frame_done = rx_end_i && active_q && !tx_busy_i;
    assign in_round   = (state_q == StReply) || (state_q == StAcknowledged) || (state_q == StOpen);
    assign ack_match  = (sr_q[15:0] == handle_q);
    assign reqrn_ok   = ((state_q == StAcknowledged) || (state_q == StOpen))
                        && (sr_q[31:16] == handle_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StReady;
            q_q       <= '0;
            slot_q    <= '0;
            session_q <= '0;
            handle_q  <= '0;
            miller_q  <= '0;
            trext_q   <= 1'b0;
            dr_q      <= 1'b0;
            tx_go_q   <= 1'b0;
            tx_len_q  <= '0;
            tx_data_q <= '0;
        end else begin
            tx_go_q <= 1'b0;
            if (frame_done) begin
                unique case (cmd)
                    CmdQuery, CmdQueryAdj: begin
                        if (cmd == CmdQuery) begin
                            dr_q      <= sr_q[17];
                            miller_q  <= {1'b0, sr_q[16:15]};
                            trext_q   <= sr_q[14];
                            session_q <= sr_q[11:10];
                        end
                        q_q      <= draw_q;
                        slot_q   <= draw_slot;
                        handle_q <= lfsr;
                        if (draw_slot == 15'd0) begin
                            state_q   <= StReply;
                            tx_go_q   <= 1'b1;
                            tx_len_q  <= RepLenRn16;
                            tx_data_q <= {96'h0, lfsr};
                        end else begin
                            state_q <= StArbitrate;
                        end
                    end
                    CmdQueryRep: begin
                        unique case (state_q)
                            StArbitrate: begin
                                if (slot_q == 15'd0) begin
                                    slot_q <= SlotWrap;
                                end else begin
                                    slot_q <= slot_q - 15'd1;
                                    if (slot_q == 15'd1) begin
                                        state_q   <= StReply;
                                        tx_go_q   <= 1'b1;
                                        tx_len_q  <= RepLenRn16;
                                        tx_data_q <= {96'h0, handle_q};
                                    end
                                end
                            end
                            StReply: begin
                                state_q <= StArbitrate;
                                slot_q  <= SlotWrap;
                            end
                            StAcknowledged, StOpen: state_q <= StReady;
                            default: ;
                        endcase
                    end
                    CmdAck: begin
                        if (in_round) begin
                            if (ack_match) begin
                                state_q   <= StAcknowledged;
                                tx_go_q   <= 1'b1;
                                tx_len_q  <= RepLenEpc;
                                tx_data_q <= {PC_WORD, EPC};
                            end else begin
                                state_q <= StArbitrate;
                            end
                        end
                    end
                    CmdReqRn: begin
                        if (reqrn_ok) begin
                            handle_q  <= lfsr;
                            state_q   <= StOpen;
                            tx_go_q   <= 1'b1;
                            tx_len_q  <= RepLenHandle;
                            tx_data_q <= {80'h0, lfsr, 16'h0};
                        end else if (in_round) begin
                            state_q <= StArbitrate;
                        end
                    end
                    default: begin
                        if (in_round) begin
                            state_q <= StArbitrate;
                        end
                    end
                endcase
            end
        end
    end

    assign tx_go_o     = tx_go_q;
    assign tx_len_o    = tx_len_q;
    assign tx_data_o   = tx_data_q;
    assign bs_miller_o = miller_q;
    assign bs_trext_o  = trext_q;
    assign bs_dr_o     = dr_q;
    assign tag_state_o = state_q;
    assign handle_o    = handle_q;

endmodule

// File: tb/tb_rfid_tag_packet_responder.sv
// Randomised bench for the tag packet responder: reference model predicts replies into a
// scoreboard queue, a negedge monitor checks every tx_go against it.
module tb_rfid_tag_packet_responder;

    localparam logic [15:0] Seed  = 16'hACE1;
    localparam logic [15:0] Pc    = 16'h3000;
    localparam logic [95:0] TbEpc = 96'h0123_4567_89AB_CDEF_0011_2233;

    localparam int KQRep  = 0;
    localparam int KAck   = 1;
    localparam int KQuery = 2;
    localparam int KQAdj  = 3;
    localparam int KReqRn = 4;
    localparam int KJunk  = 5;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         rx_start = 1'b0;
    logic         rx_bit_valid = 1'b0;
    logic         rx_bit = 1'b0;
    logic         rx_end = 1'b0;
    logic         tx_busy = 1'b0;
    logic         tx_go;
    logic [6:0]   tx_len;
    logic [111:0] tx_data;
    logic [2:0]   bs_miller;
    logic         bs_trext;
    logic         bs_dr;
    logic [2:0]   tag_state;
    logic [15:0]  handle;

    rfid_tag_packet_responder #(
        .LFSR_SEED(Seed),
        .PC_WORD  (Pc),
        .EPC      (TbEpc)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_start_i    (rx_start),
        .rx_bit_valid_i(rx_bit_valid),
        .rx_bit_i      (rx_bit),
        .rx_end_i      (rx_end),
        .tx_busy_i     (tx_busy),
        .tx_go_o       (tx_go),
        .tx_len_o      (tx_len),
        .tx_data_o     (tx_data),
        .bs_miller_o   (bs_miller),
        .bs_trext_o    (bs_trext),
        .bs_dr_o       (bs_dr),
        .tag_state_o   (tag_state),
        .handle_o      (handle)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         kind;
        logic       dr;
        logic [1:0] m;
        logic       trext;
        logic [1:0] sess;
        logic [3:0] q;
        logic [2:0] updn;
        logic [15:0] rn;
    } cmd_t;

    typedef struct {
        logic [6:0]   len;
        logic [111:0] data;
    } reply_t;

    int checks = 0;
    int failures = 0;

    // Reference model state (0 READY, 1 ARBITRATE, 2 REPLY, 3 ACKNOWLEDGED, 4 OPEN)
    int          m_state;
    int          m_q;
    int          m_slot;
    logic [1:0]  m_sess;
    logic [15:0] m_handle;
    logic        m_dr;
    logic [1:0]  m_m;
    logic        m_trext;
    logic [15:0] m_lfsr;
    bit          exp_go;
    reply_t      exp_q[$];

    always @(posedge clk or posedge reset) begin
        if (reset) m_lfsr <= Seed;
        else       m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && tx_go) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_tx_go: got len %0d data %0h expected no reply",
                         tx_len, tx_data);
            end else begin
                reply_t r;
                r = exp_q.pop_front();
                chk("tx_len", 128'(tx_len), 128'(r.len));
                chk("tx_data", 128'(tx_data), 128'(r.data));
            end
        end
    end

    task automatic m_reset();
        m_state = 0; m_q = 0; m_slot = 0; m_sess = 0; m_handle = 0;
        m_dr = 0; m_m = 0; m_trext = 0; exp_go = 0;
        exp_q.delete();
    endtask

    task automatic m_push(input logic [6:0] len, input logic [111:0] data);
        reply_t r;
        r.len = len;
        r.data = data;
        exp_q.push_back(r);
        exp_go = 1;
    endtask

    task automatic m_draw(input int q, input logic [15:0] lf);
        m_q = q;
        m_slot = int'(lf) % (1 << q);
        m_handle = lf;
        if (m_slot == 0) begin
            m_state = 2;
            m_push(7'd16, 112'(lf));
        end else begin
            m_state = 1;
        end
    endtask

    task automatic m_invalid();
        if (m_state >= 2) m_state = 1;
    endtask

    task automatic m_apply(input cmd_t c, input logic [15:0] lf);
        exp_go = 0;
        case (c.kind)
            KQuery: begin
                m_dr = c.dr; m_m = c.m; m_trext = c.trext; m_sess = c.sess;
                m_draw(int'(c.q), lf);
            end
            KQRep: begin
                if (c.sess != m_sess) m_invalid();
                else if (m_state == 1) begin
                    if (m_slot == 0) m_slot = 32767;
                    else begin
                        m_slot--;
                        if (m_slot == 0) begin
                            m_state = 2;
                            m_push(7'd16, 112'(m_handle));
                        end
                    end
                end else if (m_state == 2) begin
                    m_state = 1;
                    m_slot = 32767;
                end else if (m_state >= 3) m_state = 0;
            end
            KQAdj: begin
                if (c.sess != m_sess) m_invalid();
                else if (c.updn == 3'b110) m_draw((m_q < 15) ? m_q + 1 : 15, lf);
                else if (c.updn == 3'b011) m_draw((m_q > 0) ? m_q - 1 : 0, lf);
                else if (c.updn == 3'b000) m_draw(m_q, lf);
                else m_invalid();
            end
            KAck: begin
                if (m_state >= 2) begin
                    if (c.rn == m_handle) begin
                        m_state = 3;
                        m_push(7'd112, {Pc, TbEpc});
                    end else m_state = 1;
                end
            end
            KReqRn: begin
                if (m_state >= 3 && c.rn == m_handle) begin
                    m_handle = lf;
                    m_state = 4;
                    m_push(7'd32, 112'({lf, 16'h0000}));
                end else m_invalid();
            end
            default: m_invalid();
        endcase
    endtask

    function automatic cmd_t mk(input int kind, input logic [1:0] sess, input logic [3:0] q,
                                input logic [2:0] updn, input logic [15:0] rn);
        cmd_t c;
        c.kind = kind; c.sess = sess; c.q = q; c.updn = updn; c.rn = rn;
        c.dr = 0; c.m = 0; c.trext = 0;
        return c;
    endfunction

    task automatic build(input cmd_t c, output logic [63:0] fr, output int n);
        logic [4:0]  crc5;
        logic [15:0] crc16;
        logic [1:0]  sel;
        logic        tgt;
        crc5 = 5'($urandom);
        crc16 = 16'($urandom);
        sel = 2'($urandom);
        tgt = 1'($urandom);
        case (c.kind)
            KQRep:  begin n = 4;  fr = 64'({2'b00, c.sess}); end
            KAck:   begin n = 18; fr = 64'({2'b01, c.rn}); end
            KQuery: begin
                n = 22;
                fr = 64'({4'b1000, c.dr, c.m, c.trext, sel, c.sess, tgt, c.q, crc5});
            end
            KQAdj:  begin n = 9;  fr = 64'({4'b1001, c.sess, c.updn}); end
            KReqRn: begin n = 40; fr = 64'({8'b1100_0001, c.rn, crc16}); end
            default: begin n = 19; fr = 64'($urandom_range(0, (1 << 19) - 1)); end
        endcase
    endtask

    task automatic run_cmd(input cmd_t c, input bit busy);
        logic [63:0] fr;
        int n;
        build(c, fr, n);
        @(negedge clk);
        rx_start = 1;
        @(negedge clk);
        rx_start = 0;
        for (int i = n - 1; i >= 0; i--) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            rx_bit_valid = 1;
            rx_bit = fr[i];
            @(negedge clk);
            rx_bit_valid = 0;
        end
        rx_end = 1;
        tx_busy = busy;
        if (busy) exp_go = 0;
        else m_apply(c, m_lfsr);
        @(negedge clk);
        rx_end = 0;
        tx_busy = 0;
        chk("tx_go", 128'(tx_go), 128'(exp_go));
        chk("tag_state", 128'(tag_state), 128'(m_state));
        chk("handle", 128'(handle), 128'(m_handle));
        chk("bs_miller", 128'(bs_miller), 128'({1'b0, m_m}));
        chk("bs_trext", 128'(bs_trext), 128'(m_trext));
        chk("bs_dr", 128'(bs_dr), 128'(m_dr));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tx_go"}, 128'(tx_go), 128'(0));
        chk({tag, "_tx_len"}, 128'(tx_len), 128'(0));
        chk({tag, "_tx_data"}, 128'(tx_data), 128'(0));
        chk({tag, "_bs"}, 128'({bs_miller, bs_trext, bs_dr}), 128'(0));
        chk({tag, "_state"}, 128'(tag_state), 128'(0));
        chk({tag, "_handle"}, 128'(handle), 128'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_t c;
        m_reset();
        repeat (3) @(negedge clk);
        reset = 0;
        chk_reset_outputs("reset");

        // Q=0 always replies immediately; then full Ack / ReqRN handshake
        run_cmd(mk(KQuery, 2'd0, 4'd0, 3'd0, 16'h0), 0);
        run_cmd(mk(KAck, 2'd0, 4'd0, 3'd0, m_handle), 0);
        run_cmd(mk(KReqRn, 2'd0, 4'd0, 3'd0, m_handle), 0);
        chk("handle_nonzero", 128'(handle == 16'h0), 128'(0));
        run_cmd(mk(KReqRn, 2'd0, 4'd0, 3'd0, m_handle), 0);
        run_cmd(mk(KReqRn, 2'd0, 4'd0, 3'd0, ~m_handle), 0);

        // Q=4 round, QueryReps count down to the reply slot
        c = mk(KQuery, 2'd1, 4'd4, 3'd0, 16'h0);
        c.dr = 1; c.m = 2'd3; c.trext = 1;
        run_cmd(c, 0);
        for (int i = 0; i < 20 && m_state == 1; i++) begin
            run_cmd(mk(KQRep, 2'd1, 4'd0, 3'd0, 16'h0), 0);
        end
        chk("reached_reply", 128'(tag_state), 128'(2));
        run_cmd(mk(KAck, 2'd1, 4'd0, 3'd0, ~m_handle), 0);

        // Q saturation, session mismatch, junk, busy drop
        run_cmd(mk(KQuery, 2'd2, 4'd15, 3'd0, 16'h0), 0);
        run_cmd(mk(KQAdj, 2'd2, 4'd0, 3'b110, 16'h0), 0);
        run_cmd(mk(KQAdj, 2'd3, 4'd0, 3'b110, 16'h0), 0);
        run_cmd(mk(KJunk, 2'd0, 4'd0, 3'd0, 16'h0), 0);
        run_cmd(mk(KQAdj, 2'd2, 4'd0, 3'b011, 16'h0), 0);
        run_cmd(mk(KQuery, 2'd0, 4'd0, 3'd0, 16'h0), 1);

        // Reset while a reply is being presented
        run_cmd(mk(KQuery, 2'd0, 4'd0, 3'd0, 16'h0), 0);
        #1 reset = 1;
        #1 chk_reset_outputs("reset_reply");
        m_reset();
        @(negedge clk);
        reset = 0;

        for (int k = 0; k < 150; k++) begin
            c.kind = $urandom_range(0, 5);
            c.dr = 1'($urandom);
            c.m = 2'($urandom);
            c.trext = 1'($urandom);
            c.sess = ($urandom_range(0, 4) == 0) ? 2'($urandom) : m_sess;
            c.q = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
            c.updn = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b011 << $urandom_range(0, 1);
            c.rn = ($urandom_range(0, 3) == 0) ? 16'($urandom) : m_handle;
            run_cmd(c, $urandom_range(0, 9) == 0);
        end

        // Reset in the middle of a frame, then stray bits with no rx_start
        @(negedge clk);
        rx_start = 1;
        @(negedge clk);
        rx_start = 0;
        rx_bit_valid = 1;
        repeat (6) @(negedge clk);
        #2 reset = 1;
        #1 chk_reset_outputs("reset_frame");
        rx_bit_valid = 0;
        m_reset();
        @(negedge clk);
        reset = 0;
        rx_bit_valid = 1;
        rx_bit = 0;
        repeat (4) @(negedge clk);
        rx_bit_valid = 0;
        rx_end = 1;
        @(negedge clk);
        rx_end = 0;
        chk("stray_tx_go", 128'(tx_go), 128'(0));
        chk("stray_state", 128'(tag_state), 128'(0));
        run_cmd(mk(KQuery, 2'd0, 4'd0, 3'd0, 16'h0), 0);

        repeat (3) @(negedge clk);
        chk("pending_replies", 128'(exp_q.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
